// File: rtl/seg_serial_pkg.sv
// Shared definitions for the 74HC595 segment serial driver.
// Holds the FSM state encoding, the frame/bit-counter widths and the
// width of the shift-clock phase divider.
package seg_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } seg_state_t;

    localparam int unsigned SEG_FRAME_BITS = 64;
    localparam int unsigned SEG_BIT_CNT_W  = 6;
    // Phase divider width; covers CLK_DIV up to 255.
    localparam int unsigned SEG_DIV_W      = 8;

endpackage

// File: rtl/seg_phase_tick.sv
// Shift-clock phase timer: a CLK_DIV-cycle down-counter that flags the
// last cycle of every phase.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   clear     - reload the counter (frame accepted)
//   enable    - count this cycle (frame in progress)
//   tick_c    - high on the final cycle of the current phase
module seg_phase_tick
    import seg_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam logic [SEG_DIV_W-1:0] RELOAD = SEG_DIV_W'(CLK_DIV - 1);

    logic [SEG_DIV_W-1:0] count;

    // Down-counter, reloaded at the end of each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RELOAD;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - SEG_DIV_W'(1);
            end
        end
    end

    assign tick_c = enable && (count == '0);

endmodule

// File: rtl/seg_serial_driver.sv
// Pushes one 64-bit segment frame into the 74HC595 chain: capture on
// start, shift LSB first with a generated shift clock, pulse the
// parallel-load strobe, then pulse done.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   start     - frame request, honoured only while idle
//   seg_data  - frame, bit 0 shifted first
//   seg_clk   - shift clock (595 shifts on its rising edge)
//   seg_sout  - serial data
//   seg_pen   - parallel-load strobe, active high
//   seg_clrn  - shift-register clear, active low
//   busy      - frame in progress
//   done      - one-cycle completion pulse
module seg_serial_driver
    import seg_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SEG_FRAME_BITS-1:0] seg_data,
    output logic                      seg_clk,
    output logic                      seg_sout,
    output logic                      seg_pen,
    output logic                      seg_clrn,
    output logic                      busy,
    output logic                      done
);

    seg_state_t                state;
    // Bit 0 of the frame lives in seg_sout, so only the upper 63 bits are held here.
    logic [SEG_FRAME_BITS-2:0] shift_reg;
    logic [SEG_BIT_CNT_W-1:0]  bit_cnt;
    logic                      accept_c;
    logic                      run_c;
    logic                      tick_c;

    assign accept_c = (state == IDLE) && start;
    assign run_c    = (state == SHIFT) || (state == LATCH);

    seg_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept_c),
        .enable (run_c),
        .tick_c (tick_c)
    );

    // Sequencer: state, shift register, bit counter and all pin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            seg_clk   <= 1'b0;
            seg_sout  <= 1'b0;
            seg_pen   <= 1'b0;
            seg_clrn  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            seg_clrn <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= seg_data[SEG_FRAME_BITS-1:1];
                        seg_sout  <= seg_data[0];
                        bit_cnt   <= '0;
                        seg_clk   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_c) begin
                        if (!seg_clk) begin
                            seg_clk <= 1'b1;
                        end else begin
                            // End of high phase: present the next bit.
                            seg_clk   <= 1'b0;
                            seg_sout  <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[SEG_FRAME_BITS-2:1]};
                            bit_cnt   <= bit_cnt + SEG_BIT_CNT_W'(1);
                            if (bit_cnt == '1) begin
                                seg_pen <= 1'b1;
                                state   <= LATCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick_c) begin
                        seg_pen <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Testbench for seg_serial_driver. Three instances run concurrently
// (CLK_DIV = 2, 1, 255). Stimulus pushes expected frames and their done
// cycle into a scoreboard; a monitor models the 595 chain, pops on every
// seg_pen pulse and checks bits, edge count, phase lengths and timing.
module tb_seg_serial_driver;

    typedef struct {
        int          inst;
        logic [63:0] data;
        longint      done_cyc;
    } sb_item_t;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  start;
    logic [63:0] seg_data [3];
    logic [2:0]  seg_clk;
    logic [2:0]  seg_sout;
    logic [2:0]  seg_pen;
    logic [2:0]  seg_clrn;
    logic [2:0]  busy;
    logic [2:0]  done;

    longint   cyc;
    int       n_checks;
    int       n_pass;
    sb_item_t sb_q [$];

    int done_cnt [3];
    int pen_cnt  [3];

    seg_serial_driver #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .seg_data(seg_data[0]),
        .seg_clk(seg_clk[0]), .seg_sout(seg_sout[0]), .seg_pen(seg_pen[0]),
        .seg_clrn(seg_clrn[0]), .busy(busy[0]), .done(done[0]));

    seg_serial_driver #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .seg_data(seg_data[1]),
        .seg_clk(seg_clk[1]), .seg_sout(seg_sout[1]), .seg_pen(seg_pen[1]),
        .seg_clrn(seg_clrn[1]), .busy(busy[1]), .done(done[1]));

    seg_serial_driver #(.CLK_DIV(255)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .seg_data(seg_data[2]),
        .seg_clk(seg_clk[2]), .seg_sout(seg_sout[2]), .seg_pen(seg_pen[2]),
        .seg_clrn(seg_clrn[2]), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 255;
    endfunction

    function automatic logic [5:0] outs(input int g);
        return {seg_clk[g], seg_sout[g], seg_pen[g], seg_clrn[g], busy[g], done[g]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Issue a start from a negedge; returns the cycle in which busy first shows.
    task automatic issue(input int g, input logic [63:0] d, input bit expect_it, output longint acc);
        seg_data[g] = d;
        start[g]    = 1'b1;
        acc         = cyc + 1;
        if (expect_it) sb_q.push_back(sb_item_t'{g, d, acc + longint'(129 * div_of(g))});
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int target, input int budget);
        int t = 0;
        while (done_cnt[g] < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_count", 64'(done_cnt[g]), 64'(target));
    endtask

    task automatic reset_seq(input int g);
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs(g)), 64'(6'b000000));
        repeat (2) @(negedge clk);
        rst[g] = 1'b0;
        @(negedge clk);
        check("post_reset", 64'(outs(g)), 64'(6'b000100));
        repeat (10) @(negedge clk);
        check("idle_no_start", 64'(outs(g)), 64'(6'b000100));
    endtask

    // Monitor: 595 chain model plus timing checks, popping the scoreboard on seg_pen.
    initial begin
        logic [2:0]  p_clk, p_busy, p_pen, p_sout;
        int          run [3], perr [3], glitch [3], rises [3], pen_run [3];
        longint      pending [3];
        logic [63:0] chain [3];
        sb_item_t    it;
        int          idx;
        bit          in_shift, prev_in_shift;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (rst[g]) begin
                    p_clk[g] = 1'b0; p_busy[g] = 1'b0; p_pen[g] = 1'b0; p_sout[g] = 1'b0;
                    run[g] = 0; perr[g] = 0; glitch[g] = 0; rises[g] = 0; pen_run[g] = 0;
                    pending[g] = -1; chain[g] = '0;
                end else begin
                    in_shift      = busy[g] && !seg_pen[g];
                    prev_in_shift = p_busy[g] && !p_pen[g];
                    if (seg_clk[g] && !p_clk[g]) begin
                        chain[g] = {seg_sout[g], chain[g][63:1]};
                        rises[g]++;
                    end
                    if (in_shift) begin
                        if (prev_in_shift && seg_clk[g] == p_clk[g]) begin
                            run[g]++;
                        end else begin
                            if (prev_in_shift && run[g] != div_of(g)) perr[g]++;
                            run[g] = 1;
                        end
                    end
                    if (busy[g] && p_busy[g] && seg_sout[g] != p_sout[g] && !(p_clk[g] && !seg_clk[g]))
                        glitch[g]++;
                    if (seg_pen[g] && !p_pen[g]) begin
                        if (prev_in_shift && run[g] != div_of(g)) perr[g]++;
                        pen_cnt[g]++;
                        idx = -1;
                        for (int i = 0; i < sb_q.size(); i++)
                            if (idx < 0 && sb_q[i].inst == g) idx = i;
                        check("pen_expected", 64'(idx >= 0), 64'(1));
                        if (idx >= 0) begin
                            it = sb_q[idx];
                            sb_q.delete(idx);
                            check("shift_edges", 64'(rises[g]), 64'(64));
                            check("frame_bits", chain[g], it.data);
                            check("phase_len_errors", 64'(perr[g]), 64'(0));
                            check("sout_glitches", 64'(glitch[g]), 64'(0));
                            pending[g] = it.done_cyc;
                        end
                        rises[g] = 0; perr[g] = 0; glitch[g] = 0; chain[g] = '0;
                    end
                    if (seg_pen[g]) begin
                        pen_run[g]++;
                    end else if (p_pen[g]) begin
                        check("pen_width", 64'(pen_run[g]), 64'(div_of(g)));
                        pen_run[g] = 0;
                    end
                    if (done[g]) begin
                        done_cnt[g]++;
                        check("done_expected", 64'(pending[g] >= 0), 64'(1));
                        check("done_cycle", 64'(cyc), 64'(pending[g]));
                        pending[g] = -1;
                    end
                    p_clk[g] = seg_clk[g]; p_busy[g] = busy[g];
                    p_pen[g] = seg_pen[g]; p_sout[g] = seg_sout[g];
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst   = 3'b111;
        start = 3'b000;
        for (int g = 0; g < 3; g++) seg_data[g] = '0;
        fork
            begin : seq_div2
                longint acc;
                reset_seq(0);
                issue(0, 64'h0123_4567_89AB_CDEF, 1'b1, acc);
                wait_done(0, 1, 400);
                // Data change and start while busy must be ignored.
                @(negedge clk);
                issue(0, {$urandom, $urandom}, 1'b1, acc);
                repeat (40) @(negedge clk);
                seg_data[0] = {$urandom, $urandom};
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
                wait_done(0, 2, 400);
                repeat (300) @(negedge clk);
                check("no_queued_start", 64'(done_cnt[0]), 64'(2));
                // Abort mid-frame after bit 30's rising edge.
                issue(0, {$urandom, $urandom}, 1'b0, acc);
                while (cyc < acc + 61 * 2) @(negedge clk);
                check("bit30_clk_high", 64'(seg_clk[0]), 64'(1));
                @(negedge clk);
                #2 rst[0] = 1'b1;
                #1 check("abort_async_clear", 64'(outs(0)), 64'(6'b000000));
                repeat (3) @(negedge clk);
                rst[0] = 1'b0;
                repeat (20) @(negedge clk);
                check("abort_no_done", 64'(done_cnt[0]), 64'(2));
                check("abort_no_pen", 64'(pen_cnt[0]), 64'(2));
                issue(0, {$urandom, $urandom}, 1'b1, acc);
                wait_done(0, 3, 400);
            end
            begin : seq_div1
                longint acc;
                logic [63:0] f;
                reset_seq(1);
                // Back-to-back: start held high, frames every 130 cycles.
                f = {$urandom, $urandom};
                seg_data[1] = f;
                start[1] = 1'b1;
                acc = cyc + 1;
                sb_q.push_back(sb_item_t'{1, f, acc + 129});
                for (int m = 1; m < 4; m++) begin
                    while (cyc != acc) @(negedge clk);
                    f = {$urandom, $urandom};
                    seg_data[1] = f;
                    acc = acc + 130;
                    sb_q.push_back(sb_item_t'{1, f, acc + 129});
                end
                while (cyc != acc) @(negedge clk);
                start[1] = 1'b0;
                wait_done(1, 4, 300);
            end
            begin : seq_div255
                longint acc;
                reset_seq(2);
                issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
                wait_done(2, 1, 33100);
            end
        join
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        check("frames_div2", 64'(done_cnt[0]), 64'(3));
        check("frames_div1", 64'(done_cnt[1]), 64'(4));
        check("frames_div255", 64'(done_cnt[2]), 64'(1));
        check("pens_div1", 64'(pen_cnt[1]), 64'(4));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded cycle budget at t=%0t", $time);
        $fatal(1);
    end

endmodule
